// File: rtl/program_counter_stack.sv
// program_counter_stack: program counter with clear, load, increment and
// relative branch, plus an internal return-address stack for call/return.
// Misuse of the stack (push when full, pop when empty) sets a sticky error.
// The PC drives the shared bus through a tri-state output.
// Optional macro PC_STACK_READ_EN adds a readTop input that shows the stack
// top on the bus when read is low.
module program_counter_stack #(
  parameter int DATA_WIDTH  = 16,
  parameter int STACK_DEPTH = 8,
  parameter int INC_STEP    = 1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           notWrite,
  input  logic                           read,
  input  logic                           inc,
  input  logic                           rel,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           errClr,
`ifdef PC_STACK_READ_EN
  input  logic                           readTop,
`endif
  input  logic [DATA_WIDTH-1:0]          in,
  output logic [DATA_WIDTH-1:0]          out,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           full,
  output logic                           empty,
  output logic                           err
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam int DW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] STEP = DATA_WIDTH'(INC_STEP);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_LOAD,
    OP_CALL,
    OP_RET,
    OP_REL,
    OP_INC
  } op_t;

  logic [DATA_WIDTH-1:0]                  pc;
  logic [STACK_DEPTH-1:0][DATA_WIDTH-1:0] stack;
  logic [DATA_WIDTH-1:0]                  pc_next_seq;
  logic [AW-1:0]                          top_idx;
  logic [AW-1:0]                          push_idx;
  logic [DATA_WIDTH-1:0]                  top_val;
  op_t                                    op;
  logic                                   err_set;

  assign full        = (depth == DW'(STACK_DEPTH));
  assign empty       = (depth == '0);
  assign pc_next_seq = pc + STEP;
  // depth == STACK_DEPTH wraps the low bits to 0, so top_idx lands on the
  // last entry; depth == 0 is masked by empty wherever top_idx is used.
  assign push_idx    = depth[AW-1:0];
  assign top_idx     = depth[AW-1:0] - AW'(1);
  assign top_val     = stack[top_idx];

  // Single-winner priority decode; lower requests in the same cycle vanish.
  always_comb begin
    op = OP_HOLD;
    if (!notWrite) op = OP_LOAD;
    else if (call) op = OP_CALL;
    else if (ret)  op = OP_RET;
    else if (rel)  op = OP_REL;
    else if (inc)  op = OP_INC;
  end

  // A rejected push or pop is the only source of a new error.
  assign err_set = ((op == OP_CALL) && full) || ((op == OP_RET) && empty);

  // PC, occupancy and sticky error; clr overrides everything.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc    <= '0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      case (op)
        OP_LOAD: pc <= in;
        OP_CALL: if (!full) begin
          pc    <= in;
          depth <= depth + DW'(1);
        end
        OP_RET: if (!empty) begin
          pc    <= top_val;
          depth <= depth - DW'(1);
        end
        OP_REL:  pc <= pc + in;
        OP_INC:  pc <= pc_next_seq;
        default: ;
      endcase
      // Set wins over a simultaneous clear.
      err <= err_set | (err & ~errClr);
    end
  end

  // Return-address storage; contents need no reset since depth gates reads.
  always_ff @(posedge clk) begin
    if (!clr && (op == OP_CALL) && !full)
      stack[push_idx] <= pc_next_seq;
  end

`ifdef PC_STACK_READ_EN
  // Bus drive: PC wins over the stack-top view; empty stack reads as zero.
  always_comb begin
    out = 'z;
    if (read)
      out = pc;
    else if (readTop)
      out = empty ? '0 : top_val;
  end
`else
  // Bus drive: registered PC when read, released otherwise.
  always_comb begin
    out = 'z;
    if (read)
      out = pc;
  end
`endif

endmodule

// File: tb/tb_program_counter_stack.sv
// Directed bench for program_counter_stack (defaults: 16-bit, depth 8, step 1).
module tb_program_counter_stack;

  logic        clk = 1'b0;
  logic        clr, notWrite, read, inc, rel, call, ret, errClr;
`ifdef PC_STACK_READ_EN
  logic        readTop;
`endif
  logic [15:0] in;
  wire  [15:0] out;
  wire  [3:0]  depth;
  wire         full, empty, err;

  int total = 0;
  int bad   = 0;

  program_counter_stack #(.DATA_WIDTH(16), .STACK_DEPTH(8), .INC_STEP(1)) dut (
    .clk(clk), .clr(clr), .notWrite(notWrite), .read(read), .inc(inc),
    .rel(rel), .call(call), .ret(ret), .errClr(errClr),
`ifdef PC_STACK_READ_EN
    .readTop(readTop),
`endif
    .in(in), .out(out), .depth(depth), .full(full), .empty(empty), .err(err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    clr = 0; notWrite = 1; read = 1; inc = 0; rel = 0;
    call = 0; ret = 0; errClr = 0; in = 16'h0000;
`ifdef PC_STACK_READ_EN
    readTop = 0;
`endif
  endtask

  // Apply the current inputs for one edge, then return to idle.
  task automatic tick();
    @(posedge clk); #1;
    idle();
  endtask

  task automatic test_reset();
    // Dirty the state first so the reset has something to clear.
    notWrite = 0; in = 16'h5555; tick();
    call = 1; in = 16'h0777; tick();
    ret = 1; tick(); ret = 1; tick();   // second ret underflows -> err
    clr = 1; call = 1; in = 16'h1234; tick();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL reset_pc got=%h want=0000", out); end
    total++; if (depth !== 4'd0) begin bad++; $display("FAIL reset_depth got=%0d want=0", depth); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_load_inc_rel();
    notWrite = 0; in = 16'hFFFF; tick();
    total++; if (out !== 16'hFFFF) begin bad++; $display("FAIL load got=%h want=ffff", out); end
    inc = 1; tick();
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL inc_wrap got=%h want=0000", out); end
    rel = 1; in = 16'h0010; tick();
    total++; if (out !== 16'h0010) begin bad++; $display("FAIL rel_fwd got=%h want=0010", out); end
    rel = 1; in = 16'hFFFE; tick();
    total++; if (out !== 16'h000E) begin bad++; $display("FAIL rel_back got=%h want=000e", out); end
    // Hold: no request leaves PC alone.
    tick();
    total++; if (out !== 16'h000E) begin bad++; $display("FAIL hold got=%h want=000e", out); end
  endtask

  task automatic test_priority();
    notWrite = 0; call = 1; inc = 1; in = 16'h0100; tick();
    total++; if (out !== 16'h0100 || depth !== 4'd0) begin bad++; $display("FAIL prio_load pc=%h depth=%0d want 0100/0", out, depth); end
    call = 1; ret = 1; inc = 1; in = 16'h0500; tick();
    total++; if (out !== 16'h0500 || depth !== 4'd1) begin bad++; $display("FAIL prio_call pc=%h depth=%0d want 0500/1", out, depth); end
    ret = 1; rel = 1; inc = 1; in = 16'h0040; tick();
    total++; if (out !== 16'h0101 || depth !== 4'd0) begin bad++; $display("FAIL prio_ret pc=%h depth=%0d want 0101/0", out, depth); end
    rel = 1; inc = 1; in = 16'h0004; tick();
    total++; if (out !== 16'h0105) begin bad++; $display("FAIL prio_rel got=%h want=0105", out); end
    // errClr alone never touches PC or stack.
    errClr = 1; tick();
    total++; if (out !== 16'h0105 || depth !== 4'd0 || err !== 1'b0) begin bad++; $display("FAIL errclr_only pc=%h depth=%0d err=%b", out, depth, err); end
  endtask

  task automatic test_nested();
    notWrite = 0; in = 16'h0010; tick();
    call = 1; in = 16'h0200; tick();
    call = 1; in = 16'h0300; tick();
    total++; if (out !== 16'h0300 || depth !== 4'd2) begin bad++; $display("FAIL nest_call pc=%h depth=%0d want 0300/2", out, depth); end
    ret = 1; tick();
    total++; if (out !== 16'h0201 || depth !== 4'd1) begin bad++; $display("FAIL nest_ret1 pc=%h depth=%0d want 0201/1", out, depth); end
    ret = 1; tick();
    total++; if (out !== 16'h0011 || empty !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL nest_ret2 pc=%h empty=%b err=%b want 0011/1/0", out, empty, err); end
  endtask

  task automatic test_overflow_underflow();
    logic [15:0] model_stk [8];
    logic [15:0] exp_pc;
    notWrite = 0; in = 16'h0000; tick();
    exp_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      model_stk[i] = exp_pc + 16'h0001;
      exp_pc = 16'h1000 + 16'(i * 16);
      call = 1; in = exp_pc; tick();
    end
    total++; if (full !== 1'b1 || depth !== 4'd8 || out !== 16'h1070) begin bad++; $display("FAIL fill full=%b depth=%0d pc=%h want 1/8/1070", full, depth, out); end
    call = 1; in = 16'hAAAA; tick();
    total++; if (out !== 16'h1070 || depth !== 4'd8 || err !== 1'b1) begin bad++; $display("FAIL overflow pc=%h depth=%0d err=%b want 1070/8/1", out, depth, err); end
    inc = 1; tick();   // err stays set across other ops
    exp_pc = 16'h1071;
    total++; if (err !== 1'b1 || out !== exp_pc) begin bad++; $display("FAIL err_sticky err=%b pc=%h", err, out); end
    errClr = 1; tick();
    total++; if (err !== 1'b0 || depth !== 4'd8) begin bad++; $display("FAIL errclr err=%b depth=%0d want 0/8", err, depth); end
    for (int i = 7; i >= 0; i--) begin
      ret = 1; tick();
      total++; if (out !== model_stk[i] || depth !== 4'(i)) begin bad++; $display("FAIL pop%0d pc=%h depth=%0d want %h/%0d", i, out, depth, model_stk[i], i); end
    end
    exp_pc = model_stk[0];
    ret = 1; tick();
    total++; if (out !== exp_pc || depth !== 4'd0 || err !== 1'b1) begin bad++; $display("FAIL underflow pc=%h depth=%0d err=%b want %h/0/1", out, depth, err, exp_pc); end
    errClr = 1; tick();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL errclr2 got=%b want=0", err); end
    errClr = 1; ret = 1; tick();
    total++; if (err !== 1'b1 || out !== exp_pc) begin bad++; $display("FAIL set_wins err=%b pc=%h want 1/%h", err, out, exp_pc); end
    clr = 1; tick();
    total++; if (err !== 1'b0 || depth !== 4'd0) begin bad++; $display("FAIL clr_err err=%b depth=%0d want 0/0", err, depth); end
  endtask

`ifdef PC_STACK_READ_EN
  task automatic test_read_top();
    notWrite = 0; in = 16'h0040; tick();
    call = 1; in = 16'h0080; tick();
    read = 0; readTop = 1; #1;
    total++; if (out !== 16'h0041) begin bad++; $display("FAIL readtop got=%h want=0041", out); end
    read = 1; #1;
    total++; if (out !== 16'h0080) begin bad++; $display("FAIL read_wins got=%h want=0080", out); end
    idle();
    ret = 1; tick();
    read = 0; readTop = 1; #1;
    total++; if (out !== 16'h0000) begin bad++; $display("FAIL readtop_empty got=%h want=0000", out); end
    idle();
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_load_inc_rel();
    test_priority();
    test_nested();
    test_overflow_underflow();
`ifdef PC_STACK_READ_EN
    test_read_top();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a task ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_counter_stack.md
Name: program_counter_stack

Overview:
Parametrised successor to the CPU program counter. It holds the current PC and supports clear, absolute load, increment and relative branch. It also has an internal return-address stack for call/return, with sticky error reporting on stack misuse. The PC value drives the shared data bus through a tri-state output, so the block sits on the same bus as the other register blocks.

Parameters:
DATA_WIDTH, 16, width of PC, bus and stack entries
STACK_DEPTH, 8, number of return-address entries; power of two, >= 2
INC_STEP, 1, amount added by inc; must be < 2^DATA_WIDTH

Ports:
clk  input  1  system clock, all state updates on posedge
clr  input  1  synchronous active-high reset
notWrite  input  1  active-low absolute load: PC <= in
read  input  1  drive PC onto out; otherwise out is high-Z
inc  input  1  PC <= PC + INC_STEP
rel  input  1  PC <= PC + in (two's complement offset)
call  input  1  push PC + INC_STEP, then PC <= in
ret  input  1  pop stack top into PC
errClr  input  1  clear sticky error flag
in  input  DATA_WIDTH  load value, call target or relative offset
out  output  DATA_WIDTH  tri-state PC value
depth  output  $clog2(STACK_DEPTH)+1  current stack occupancy
full  output  1  depth == STACK_DEPTH
empty  output  1  depth == 0
err  output  1  sticky: overflow or underflow occurred

Behaviour:
- clk and clr: one clock; reset is synchronous and active-high.
- On clr at posedge: PC = 0, depth = 0, err = 0. Stack contents are don't-care. clr overrides every other input in that cycle, including a call or ret issued at the same time.
- Exactly one operation executes per cycle, chosen by priority: clr > !notWrite > call > ret > rel > inc > hold. Lower-priority requests in the same cycle are ignored and have no side effects.
- Load: PC = in.
- inc: PC = PC + INC_STEP modulo 2^DATA_WIDTH. Wraps, e.g. 0xFFFF + 1 = 0x0000 at width 16.
- rel: PC = PC + in modulo 2^DATA_WIDTH. in is interpreted as two's complement, so 0xFFFE means -2.
- call when not full:
  - stack[depth] = PC + INC_STEP (wrapped), depth = depth + 1, PC = in.
  - All updates happen in the same cycle.
- call when full: no push, PC unchanged, err = 1.
- ret when not empty: PC = stack[depth-1], depth = depth - 1.
- ret when empty: PC unchanged, depth stays 0, err = 1.
- err handling:
  - err is sticky until errClr or clr.
  - If errClr and a new error occur in the same cycle, err = 1 (set wins).
  - errClr has no effect on PC or stack.
- out = read ? PC : all-Z, combinational. out shows the registered PC value, not the value being written this cycle.
- full and empty are combinational decodes of the registered depth.
- Latency: every operation is visible on out (with read=1) in the cycle after the edge; a ret returns data with one-edge latency.
- Stack storage is a register array indexed by depth. No bypass is needed because only one push or pop can happen per cycle.

Optional Feature:
PC_STACK_READ_EN
- Defined:
  - Adds input readTop (1 bit).
  - When readTop=1 and read=0, out = stack[depth-1], or all zeros if empty.
  - When read=1, out = PC regardless of readTop (read wins).
  - The stack is not modified by readTop.
  - Used for debugger/context-save of the return stack.
- Undefined: the readTop port does not exist and out depends only on read.

Test Plan:
- clr=1 for one edge with call=1, in=0x1234 -> PC=0x0000, depth=0, empty=1, err=0; out with read=1 reads 0x0000, with read=0 reads Z.
- Load: notWrite=0, in=0xFFFF, then inc one edge -> PC=0x0000 (wrap). Then rel with in=0x0010 -> 0x0010. Then rel with in=0xFFFE -> 0x000E.
- Priority: notWrite=0, in=0x0100 together with call=1 and inc=1 -> PC=0x0100 and depth unchanged (0).
- Nested calls: PC=0x0010, call in=0x0200, then call in=0x0300 -> depth=2, PC=0x0300. Then ret -> PC=0x0201. Then ret -> PC=0x0011, empty=1.
- Overflow/underflow:
  - Fill with 8 calls -> full=1.
  - 9th call, in=0xAAAA -> PC unchanged, depth=8, err=1.
  - errClr -> err=0.
  - 8 rets, then one extra ret -> PC unchanged, err=1.
  - errClr and underflow in the same cycle -> err=1.
- With PC_STACK_READ_EN defined: after call from 0x0040 -> readTop=1, read=0 gives out=0x0041. With read=1 as well, out=PC. With the stack empty, readTop gives 0x0000.
